// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels of the ALU command sequencer.
// The master side issues register-to-register or load-immediate commands and
// consumes responses. The slave side is the sequencer.
interface alu_cmd_sequencer_if;
  // command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_srca;
  logic [1:0] cmd_srcb;
  logic       cmd_use_carry;
  logic [7:0] cmd_imm;
  // response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [2:0] rsp_flags;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_srca, cmd_srcb,
           cmd_use_carry, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_srca, cmd_srcb,
           cmd_use_carry, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer wrapped around an external combinational 8-bit ALU.
// Holds a 4 x 8-bit register file and a {C,Z,N} flag register, drives the ALU
// from registered operand latches, writes the ALU result back one cycle after
// accept and presents every result with its flags on the response channel.
module alu_cmd_sequencer (
  input  logic                      clk,
  input  logic                      rst_n,
  alu_cmd_sequencer_if.slave        bus,
  output logic [7:0]                alu_a,
  output logic [7:0]                alu_b,
  output logic [2:0]                alu_opcode,
  output logic                      alu_carry_in,
  input  logic [7:0]                alu_result,
  input  logic                      alu_carry_out,
  input  logic                      alu_zero,
  input  logic                      alu_negative,
  input  logic [1:0]                rd_addr,
  output logic [7:0]                rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;

  logic [7:0]  regs_r [4];
  logic [2:0]  flags_r;        // {C, Z, N}
  logic [7:0]  rsp_result_r;
  logic [1:0]  dst_r;
  logic [7:0]  alu_a_r;
  logic [7:0]  alu_b_r;
  logic [2:0]  alu_opcode_r;
  logic        alu_carry_in_r;

  logic        load_acc_s;     // load command accepted this cycle
  logic        alu_acc_s;      // ALU command accepted this cycle
  logic        wb_s;           // ALU result written back this cycle

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    next_state_s = state_r;
    load_acc_s   = 1'b0;
    alu_acc_s    = 1'b0;
    wb_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_load) begin
            load_acc_s   = 1'b1;
            next_state_s = ST_RESP;
          end else begin
            alu_acc_s    = 1'b1;
            next_state_s = ST_EXEC;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        wb_s         = 1'b1;
        next_state_s = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Register file, flags, response data and ALU operand latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 8'h00;
      end
      flags_r        <= 3'b000;
      rsp_result_r   <= 8'h00;
      dst_r          <= 2'd0;
      alu_a_r        <= 8'h00;
      alu_b_r        <= 8'h00;
      alu_opcode_r   <= 3'b000;
      alu_carry_in_r <= 1'b0;
    end else if (load_acc_s) begin
      // Load keeps C and leaves the ALU latches untouched.
      regs_r[bus.cmd_dst] <= bus.cmd_imm;
      rsp_result_r        <= bus.cmd_imm;
      flags_r             <= {flags_r[2], (bus.cmd_imm == 8'h00), bus.cmd_imm[7]};
    end else if (alu_acc_s) begin
      // Sources are sampled here; any earlier writeback has already landed.
      alu_a_r        <= regs_r[bus.cmd_srca];
      alu_b_r        <= regs_r[bus.cmd_srcb];
      alu_opcode_r   <= bus.cmd_op;
      alu_carry_in_r <= bus.cmd_use_carry ? flags_r[2] : 1'b0;
      dst_r          <= bus.cmd_dst;
    end else if (wb_s) begin
      regs_r[dst_r] <= alu_result;
      rsp_result_r  <= alu_result;
      flags_r       <= {alu_carry_out, alu_zero, alu_negative};
    end
  end

  assign bus.cmd_ready  = (state_r == ST_IDLE);
  assign bus.rsp_valid  = (state_r == ST_RESP);
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_flags  = flags_r;

  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_opcode   = alu_opcode_r;
  assign alu_carry_in = alu_carry_in_r;

  assign rd_data = regs_r[rd_addr];

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer that sits directly upstream of the 8-bit ALU and also captures its outputs. It accepts register-to-register commands over a valid/ready handshake and holds a 4-entry × 8-bit register file plus a C/Z/N flag register. It drives the ALU operand, opcode and carry-in lines from registered latches, writes the ALU result back, and presents each result with its flags on a valid/ready response port. The ALU itself stays purely combinational and is instantiated outside this block.

## Interface
- No parameters. Register count (4), data width (8) and opcode width (3) are fixed.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; equals (state == IDLE)
- cmd_load  in  1  1 = load immediate, 0 = ALU operation
- cmd_op  in  3  ALU opcode (000 ADD … 111 SHR); ignored when cmd_load=1
- cmd_dst  in  2  destination register index
- cmd_srca  in  2  source register for the ALU A input
- cmd_srcb  in  2  source register for the ALU B input
- cmd_use_carry  in  1  1 = drive the flag register's C onto alu_carry_in; 0 = drive 0
- cmd_imm  in  8  immediate value for load commands
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_opcode  out  3  to ALU Opcode
- alu_carry_in  out  1  to ALU Carry_in
- alu_result  in  8  from ALU Result
- alu_carry_out  in  1  from ALU Carry_out
- alu_zero  in  1  from ALU Zero
- alu_negative  in  1  from ALU Negative
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  8  value written to the destination register
- rsp_flags  out  3  {C, Z, N} after the command
- rd_addr  in  2  debug read index
- rd_data  out  8  combinational read of regfile[rd_addr]

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - On cmd_valid && cmd_ready with cmd_load=0: latch regfile[srca]→alu_a, regfile[srcb]→alu_b, cmd_op→alu_opcode, (cmd_use_carry ? C : 0)→alu_carry_in, and cmd_dst. Go to EXEC.
  - On accept with cmd_load=1: write cmd_imm to regfile[dst] and set rsp_result=cmd_imm. Set Z=(imm==0) and N=imm[7]; C is unchanged. Go to RESP.
- EXEC (exactly one cycle): at the end of the cycle:
  - regfile[dst] ← alu_result
  - rsp_result ← alu_result
  - C ← alu_carry_out, Z ← alu_zero, N ← alu_negative
  - Go to RESP.
- RESP: hold rsp_valid=1 and keep rsp_result/rsp_flags stable. On rsp_ready, go to IDLE.
- The rsp_flags output always reflects the flag register.
- Sources are read at the accept edge. Writeback completes before the next accept, so dst==srca/srcb and back-to-back dependent commands have no hazard.
- Opcodes whose ALU carry-out is 0 (AND/OR/XOR/NOT) clear C.
- rd_data reflects a write on the cycle after the write edge.
- The alu_* latches hold their last values in IDLE and RESP. They change only on an accepted ALU command; a load command does not alter them.

## Timing
- Reset (asynchronous, while rst_n=0):
  - state=IDLE, so cmd_ready=1
  - rsp_valid=0, rsp_result=0x00, rsp_flags=000
  - all registers 0x00
  - alu_a=alu_b=0x00, alu_opcode=000, alu_carry_in=0
- ALU command accepted at edge E0: alu_* valid in cycle E0→E1, writeback and rsp_valid=1 after E1. Latency is 2 edges.
- Load command accepted at E0: rsp_valid=1 and register updated after E0. Latency is 1 edge.
- rsp_ready held high: one ALU command every 3 cycles, one load every 2 cycles.
- rsp_ready may be high before rsp_valid; the handshake completes on the first edge where both are 1.
- cmd_ready=0 in EXEC and RESP. A cmd_valid arriving then is not consumed, and command inputs are ignored.
- Reset mid-operation (in EXEC or RESP): the command is abandoned, with no writeback and no response. All outputs return to their reset values immediately.

## Test plan
- Reset: pulse rst_n low mid-idle → cmd_ready=1, rsp_valid=0, rd_data=0x00 for all four indices, alu_a/alu_b/alu_opcode/alu_carry_in all 0.
- Load R0=0xF0, then R1=0x20; ADD R2=R0+R1 with use_carry=0 → rsp_result=0x10, rsp_flags C=1 Z=0 N=0 exactly 2 edges after accept; rd_addr=2 reads 0x10.
- Carry chaining: after the previous step, ADD R3=R1+R1 with use_carry=1 → alu_carry_in=1 during EXEC, rsp_result=0x41, flags C=0 Z=0 N=0.
- SUB R0=R1−R0 (0x20−0xF0) → 0x30, C=1; then SUB R2=R2−R2 → 0x00, Z=1, C=0; then load 0x80 → Z=0, N=1, C unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 asserted → rsp_valid, rsp_result and rsp_flags stable, cmd_ready=0, no second accept; on releasing rsp_ready the pending command is accepted the next cycle.
- Reset during EXEC of ADD into R3 (old R3=0x41) → rsp_valid never asserts, R3=0x00, flags=000, cmd_ready=1 after reset release.
